seq_shifter: RTL

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_step.sv | 63 ++++++
 rtl/seq_shifter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared definitions for the sequential shifter. It holds the
//            operation encodings and the controller state type.
// Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

    // Operation encodings presented on the op port
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-step shifter. It applies one shift of
//            distance k (0..STEP) for the selected operation. Each output bit
//            is a (STEP+1)-input mux over neighbouring input bits, so no
//            full barrel shifter is built.
// Ports    : data_in  [WIDTH-1:0]          operand for this step
//            op       [1:0]                SLL / SRL / SRA / ROTR
//            k        [clog2(STEP+1)-1:0]  distance for this step, 0..STEP
//            data_out [WIDTH-1:0]          shifted operand
// Revision : 1.0  initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]           data_in,
    input  logic [1:0]                 op,
    input  logic [$clog2(STEP+1)-1:0]  k,
    output logic [WIDTH-1:0]           data_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // w_cand[j] is the value of output bit i for a shift distance of j
        logic [STEP:0] w_cand;

        for (genvar j = 0; j <= STEP; j++) begin : g_cand
            logic w_sll;
            logic w_srl;
            logic w_sra;
            logic w_rot;

            if (i >= j) begin : g_sll_src
                assign w_sll = data_in[i-j];
            end else begin : g_sll_zero
                assign w_sll = 1'b0;
            end

            // While an SRA is in progress the working MSB still holds the
            // captured operand MSB, so it is the correct fill bit.
            if (i + j < WIDTH) begin : g_right_src
                assign w_srl = data_in[i+j];
                assign w_sra = data_in[i+j];
            end else begin : g_right_fill
                assign w_srl = 1'b0;
                assign w_sra = data_in[WIDTH-1];
            end

            assign w_rot = data_in[(i+j) % WIDTH];

            assign w_cand[j] = (op == OP_SLL) ? w_sll :
                               (op == OP_SRL) ? w_srl :
                               (op == OP_SRA) ? w_sra : w_rot;
        end

        assign data_out[i] = w_cand[k];
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Purpose  : Multi-cycle shifter. An accepted start captures the operand,
//            the operation and the shift amount. Each SHIFT cycle then moves
//            the working register by up to STEP bit positions until the
//            remaining distance is zero. done pulses for one cycle when the
//            result is valid.
// Ports    : clk      rising-edge clock
//            rst_n    asynchronous active-low reset
//            start    request a new operation (honoured when busy=0)
//            op       00 SLL, 01 SRL, 10 SRA, 11 ROTR
//            data_in  operand, WIDTH bits
//            shamt    unsigned shift amount, SHAMT_W bits
//            abort    cancels an operation in SHIFT; has priority over start
//            busy     high while in SHIFT
//            done     one-cycle result-valid pulse
//            result   working register / shifted value
// Revision : 1.0  initial release
// ============================================================================
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    // Width needed to express a per-cycle distance of 0..STEP
    localparam int c_k_w = $clog2(STEP + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   w_step_out;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_rem;
    logic [SHAMT_W-1:0] w_rem_nxt;
    logic [c_k_w-1:0]   w_k;
    logic               w_accept;

    // k = min(STEP, remaining). The subtraction below cannot wrap because
    // k never exceeds r_rem.
    assign w_k       = (r_rem > SHAMT_W'(STEP)) ? c_k_w'(STEP) : r_rem[c_k_w-1:0];
    assign w_rem_nxt = r_rem - SHAMT_W'(w_k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_step (
        .data_in  (r_work),
        .op       (r_op),
        .k        (w_k),
        .data_out (w_step_out)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and accept decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // abort has no effect outside SHIFT
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rem_nxt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture on accept, step while shifting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_op   <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_work <= data_in;
            r_op   <= op;
            r_rem  <= shamt;
        end else if (r_state == ST_SHIFT) begin
            if (abort) begin
                r_rem <= '0;
            end else begin
                r_work <= w_step_out;
                r_rem  <= w_rem_nxt;
            end
        end
    end

    assign busy   = (r_state == ST_SHIFT);
    assign done   = (r_state == ST_DONE);
    assign result = r_work;

endmodule : seq_shifter
`default_nettype wire
